// File: rtl/uart_tx_os_if.sv
// rtl/uart_tx_os_if.sv - byte handshake between a producer and the oversampled UART transmitter
interface uart_tx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_os.sv
// rtl/uart_tx_os.sv - UART transmitter timed by an external oversampling baud tick
// Optional parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         boud_in,
    uart_tx_os_if.slave  s,
    output logic         tx,
    output logic         busy,
    output logic         done
);
    localparam int             CW        = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]     IDX_LAST  = 4'(DATA_BITS - 1);
    localparam logic           STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        tick_q, tick_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;
    logic                 accept;
    logic                 parity_bit;

    assign bit_end = boud_in && (state_q != S_IDLE) && (tick_q == TICK_LAST);
    assign accept  = s.tx_valid && ready_q;

`ifdef UART_TX_PARITY_EN
    localparam logic PODD = (PARITY_ODD != 0);
    logic [DATA_BITS-1:0] data_q, data_d;

    // Parity comes from the byte as accepted; the shift register is consumed by then.
    assign parity_bit = (^data_q) ^ PODD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    always_comb begin
        data_d = data_q;
        if (state_q == S_IDLE && accept) begin
            data_d = s.tx_data;
        end
    end
`else
    assign parity_bit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;

        // The tick in the acceptance cycle is not counted: IDLE never advances the counter.
        if (state_q != S_IDLE && boud_in) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_START;
                    shift_d    = s.tx_data;
                    tick_d     = '0;
                    bit_idx_d  = '0;
                    stop_cnt_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d    = S_IDLE;
                        stop_cnt_d = 1'b0;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they land in flops alongside it.
    always_comb begin
        tx_d    = 1'b1;
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_STOP) && bit_end && (stop_cnt_q == STOP_LAST);
        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_bit;
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign s.tx_ready = ready_q;
endmodule

// File: tb/tb_uart_tx_os.sv
// tb/tb_uart_tx_os.sv - self-checking bench for uart_tx_os against a tick-counting frame model
module tb_uart_tx_os;
    localparam int DB = 8;
    localparam int OS = 16;
    localparam int SB = 1;
    localparam int PO = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
    localparam logic [10:0] V_A5 = 11'h54A;
    localparam logic [10:0] V_3C = 11'h478;
    localparam logic [10:0] V_07 = 11'h60E;
`else
    localparam int PAR = 0;
    localparam logic [9:0] V_A5 = 10'h34A;
    localparam logic [9:0] V_3C = 10'h278;
`endif
    localparam int NB = 1 + DB + PAR + SB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic boud_in = 1'b0;
    logic tx, busy, done;
    int   checks = 0;
    int   failures = 0;
    int   period = 0;
    int   bcnt = 0;
    bit   chk_en = 1'b0;

    uart_tx_os_if #(.DATA_BITS(DB)) bus ();

    uart_tx_os #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .STOP_BITS (SB),
        .PARITY_ODD(PO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .boud_in(boud_in),
        .s      (bus.slave),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        bcnt++;
        boud_in = (period == 0) ? 1'b0 : ((bcnt % period) == 0);
    end

    // Frame model: line value is the frame bit indexed by ticks elapsed since acceptance.
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_ticks = 0;
    bit fr [0:NB-1];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_ticks = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (boud_in) begin
                    m_ticks++;
                    if (m_ticks == NB * OS) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else if (bus.tx_valid) begin
                fr[0] = 1'b0;
                for (int i = 0; i < DB; i++) fr[1 + i] = bus.tx_data[i];
`ifdef UART_TX_PARITY_EN
                fr[1 + DB] = (^bus.tx_data) ^ (PO != 0);
`endif
                for (int i = 0; i < SB; i++) fr[1 + DB + PAR + i] = 1'b1;
                m_busy  = 1'b1;
                m_ticks = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] expv;
        if (chk_en && !rst) begin
            expv = {(m_busy ? fr[m_ticks / OS] : 1'b1), !m_busy, m_busy, m_done};
            checks++;
            if ({tx, bus.tx_ready, busy, done} !== expv) begin
                failures++;
                $display("FAIL model_cycle t=%0t {tx,ready,busy,done} got=%b want=%b", $time,
                         {tx, bus.tx_ready, busy, done}, expv);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", nm, act, expv);
        end
    endtask

    task automatic wait_ready(input string nm);
        for (int i = 0; i < 5000 && bus.tx_ready !== 1'b1; i++) @(negedge clk);
        if (bus.tx_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_ready_timeout got=%b want=1", nm, bus.tx_ready);
        end
    endtask

    task automatic wait_done(input string nm);
        int i;
        for (i = 0; i < 5000 && done !== 1'b1; i++) @(negedge clk);
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_done_timeout got=%b want=1", nm, done);
        end
    endtask

    // Samples the middle of every bit period with a tick on every clock.
    task automatic send_sample(input logic [7:0] d, input logic [NB-1:0] expv, input string nm);
        logic [NB-1:0] vec;
        int            done_at;
        vec     = '0;
        done_at = -1;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        wait_ready(nm);
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        for (int n = 0; n <= NB * OS; n++) begin
            @(negedge clk);
            if (n % OS == OS / 2) vec[n / OS] = tx;
            if (done === 1'b1 && done_at < 0) done_at = n;
        end
        chk({nm, "_bits"}, 32'(vec), 32'(expv));
        chk({nm, "_done_lat"}, done_at, NB * OS);
    endtask

    initial begin
        int lo_cnt;
        int hi_cnt;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_ready", bus.tx_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        period = 1;
        repeat (4) @(negedge clk);
        send_sample(8'hA5, V_A5, "a5");

        period = 4;
        bus.tx_data = 8'h00;
        wait_ready("zero");
        for (int i = 0; i < 10 && boud_in !== 1'b1; i++) @(negedge clk);
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        lo_cnt = 0;
        hi_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (tx === 1'b0) lo_cnt++;
            else if (busy === 1'b1) hi_cnt++;
        end
        chk("zero_low_cycles", lo_cnt, (NB - SB) * OS * 4);
        chk("zero_high_cycles", hi_cnt, SB * OS * 4);

        period = 1;
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
        wait_ready("b2b");
        @(posedge clk);
        #1 bus.tx_data = 8'h0F;
        @(negedge clk);
        wait_done("b2b_first");
        chk("b2b_ready_at_done", bus.tx_ready, 1);
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        @(negedge clk);
        chk("b2b_gap_tx", tx, 0);
        chk("b2b_gap_busy", busy, 1);
        repeat (50) @(negedge clk);
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_done("b2b_second");
        repeat (20) @(negedge clk);
        chk("ff_ignored_busy", busy, 0);

        bus.tx_data  = 8'h96;
        bus.tx_valid = 1'b1;
        wait_ready("abort");
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        repeat (OS * 4 + 5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_ready", bus.tx_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_sample(8'h3C, V_3C, "post_rst");

        bus.tx_data  = 8'hC3;
        bus.tx_valid = 1'b1;
        wait_ready("pause");
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
        repeat (OS * 3 + OS / 2 + 1) @(negedge clk);
        period = 0;
        repeat (100) @(negedge clk);
        chk("pause_hold_tx", tx, 0);
        chk("pause_hold_busy", busy, 1);
        period = 1;
        wait_done("pause");

`ifdef UART_TX_PARITY_EN
        repeat (4) @(negedge clk);
        send_sample(8'h07, V_07, "parity");
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
